// File: rtl/ctrl_uart2fifo_pkg.sv
// ctrl_uart2fifo_pkg: shared types and constants for the UART-to-FIFO sample reassembler.
package ctrl_uart2fifo_pkg;

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } state_t;

    localparam int UART_BYTE_W = 8;

    // Number of sample bits carried in the second (high) byte.
    function automatic int hi_bits_w(input int data_w);
        return data_w - UART_BYTE_W;
    endfunction

endpackage

// File: rtl/ctrl_uart2fifo.sv
// ctrl_uart2fifo: reassembles little-endian byte pairs from the UART receiver into
// DATA_W-bit samples and writes them to the DAC-side FIFO with a one-cycle strobe.
// Framing (nonzero unused high-byte bits) and overflow (FIFO full) drop the pair and
// pulse an error flag; the next byte is always treated as a low byte.
// Optional: define CTRL_UART2FIFO_TIMEOUT_EN to abandon a half-received pair after
// TIMEOUT_CYC idle cycles in the high-byte state.
module ctrl_uart2fifo
    import ctrl_uart2fifo_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx_done,
    input  logic [UART_BYTE_W-1:0] uart_rx_data,
    output logic                   fifo_wrreq,
    output logic [DATA_W-1:0]      fifo_data,
    input  logic                   fifo_full,
    output logic                   err_overflow,
    output logic                   err_frame
);

    localparam int HI_W = hi_bits_w(DATA_W);

    // Bits of the high byte that may legally carry sample data; anything outside
    // is a framing error. With DATA_W=16 the mask is all ones and framing never fails.
    localparam logic [UART_BYTE_W-1:0] HI_MASK = UART_BYTE_W'((1 << HI_W) - 1);

    state_t                 state, state_nx;
    logic [UART_BYTE_W-1:0] lo_byte, lo_byte_nx;
    logic                   wrreq_nx, ovf_nx, frame_nx;
    logic [DATA_W-1:0]      data_nx;
    logic                   frame_bad;

`ifdef CTRL_UART2FIFO_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] timer;
    logic               timer_expired;

    assign timer_expired = (timer == TIMER_LAST);

    // Idle timer: held at zero in S_LO so it starts from zero on every entry to S_HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == S_HI && state_nx == S_HI) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end
`endif

    assign frame_bad = |(uart_rx_data & ~HI_MASK);

    // State, held low byte and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_LO;
            lo_byte      <= '0;
            fifo_wrreq   <= 1'b0;
            fifo_data    <= '0;
            err_overflow <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            state        <= state_nx;
            lo_byte      <= lo_byte_nx;
            fifo_wrreq   <= wrreq_nx;
            fifo_data    <= data_nx;
            err_overflow <= ovf_nx;
            err_frame    <= frame_nx;
        end
    end

    // Next-state and next-output decode; pulses default low, fifo_data defaults to hold.
    always_comb begin
        state_nx   = state;
        lo_byte_nx = lo_byte;
        wrreq_nx   = 1'b0;
        ovf_nx     = 1'b0;
        frame_nx   = 1'b0;
        data_nx    = fifo_data;
        case (state)
            S_LO: begin
                if (uart_rx_done) begin
                    lo_byte_nx = uart_rx_data;
                    state_nx   = S_HI;
                end
            end
            S_HI: begin
                if (uart_rx_done) begin
                    state_nx = S_LO;
                    if (frame_bad) begin
                        frame_nx = 1'b1;
                    end else if (fifo_full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        wrreq_nx = 1'b1;
                        data_nx  = {uart_rx_data[HI_W-1:0], lo_byte};
                    end
                end
`ifdef CTRL_UART2FIFO_TIMEOUT_EN
                else if (timer_expired) begin
                    state_nx   = S_LO;
                    lo_byte_nx = '0;
                end
`endif
            end
            default: begin
                state_nx = S_LO;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_uart2fifo.sv
// tb_ctrl_uart2fifo: directed byte-pair stimulus with a scoreboard of hand-computed
// expected pulses; a negedge monitor pops and checks each pulse as it appears.
module tb_ctrl_uart2fifo;

    localparam int DATA_W = 12;
    localparam int KIND_WR  = 1;
    localparam int KIND_FRM = 2;
    localparam int KIND_OVF = 4;

    typedef struct {
        int          kind;
        logic [11:0] data;
        int          cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              uart_rx_done;
    logic [7:0]        uart_rx_data;
    logic              fifo_wrreq;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              err_overflow;
    logic              err_frame;

    exp_t exp_q[$];
    int   cyc;
    int   total;
    int   bad;

    ctrl_uart2fifo #(
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx_done(uart_rx_done),
        .uart_rx_data(uart_rx_data),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_data   (fifo_data),
        .fifo_full   (fifo_full),
        .err_overflow(err_overflow),
        .err_frame   (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one byte for one cycle; kind/data give the pulse expected one clk later.
    task automatic send_byte(input logic [7:0] b, input logic full,
                             input int kind, input logic [11:0] data);
        exp_t e;
        @(negedge clk);
        uart_rx_done = 1'b1;
        uart_rx_data = b;
        fifo_full    = full;
        if (kind != 0) begin
            e.kind = kind;
            e.data = data;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            uart_rx_done = 1'b0;
            uart_rx_data = 8'h00;
            fifo_full    = 1'b0;
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [2:0] ev;
            exp_t e;
            ev = {err_overflow, err_frame, fifo_wrreq};
            if (ev != 3'b000) begin
                check("pulse_onehot", $countones(ev), 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got kind %0d data 0x%0h at cycle %0d, expected none",
                             ev, fifo_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", int'(ev), e.kind);
                    check("fifo_data", int'(fifo_data), int'(e.data));
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        uart_rx_done = 1'b0;
        uart_rx_data = 8'h00;
        fifo_full    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wrreq", fifo_wrreq, 0);
        check("reset_data", int'(fifo_data), 0);
        check("reset_ovf", err_overflow, 0);
        check("reset_frame", err_frame, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic pair.
        send_byte(8'h34, 1'b0, 0, 12'h000);
        send_byte(8'h02, 1'b0, KIND_WR, 12'h234);
        idle(3);

        // Back-to-back bytes, including full-range and top-bit-only samples.
        send_byte(8'hFF, 1'b0, 0, 12'h000);
        send_byte(8'h0F, 1'b0, KIND_WR, 12'hFFF);
        send_byte(8'h00, 1'b0, 0, 12'h000);
        send_byte(8'h08, 1'b0, KIND_WR, 12'h800);
        idle(3);

        // Framing error then realigned pair.
        send_byte(8'h12, 1'b0, 0, 12'h000);
        send_byte(8'h31, 1'b0, KIND_FRM, 12'h800);
        send_byte(8'h56, 1'b0, 0, 12'h000);
        send_byte(8'h04, 1'b0, KIND_WR, 12'h456);
        idle(3);

        // Overflow leaves fifo_data unchanged; next pair writes normally.
        send_byte(8'hAB, 1'b0, 0, 12'h000);
        send_byte(8'h01, 1'b1, KIND_OVF, 12'h456);
        send_byte(8'hCD, 1'b0, 0, 12'h000);
        send_byte(8'h00, 1'b0, KIND_WR, 12'h0CD);
        idle(2);

        // Framing takes priority over overflow; fifo_full outside the high byte is ignored.
        send_byte(8'h00, 1'b1, 0, 12'h000);
        send_byte(8'h10, 1'b1, KIND_FRM, 12'h0CD);
        idle(3);

        // Reset mid-pair discards the low byte and ignores rx_done during reset.
        send_byte(8'h77, 1'b0, 0, 12'h000);
        @(negedge clk);
        rst_n        = 1'b0;
        uart_rx_done = 1'b1;
        uart_rx_data = 8'h55;
        #1;
        check("midreset_wrreq", fifo_wrreq, 0);
        check("midreset_data", int'(fifo_data), 0);
        check("midreset_ovf", err_overflow, 0);
        check("midreset_frame", err_frame, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h10, 1'b0, 0, 12'h000);
        send_byte(8'h03, 1'b0, KIND_WR, 12'h310);
        idle(3);

        // Long idle between low and high byte.
        send_byte(8'h99, 1'b0, 0, 12'h000);
        idle(20);
`ifdef CTRL_UART2FIFO_TIMEOUT_EN
        send_byte(8'h22, 1'b0, 0, 12'h000);
        send_byte(8'h01, 1'b0, KIND_WR, 12'h122);
`else
        send_byte(8'h22, 1'b0, KIND_FRM, 12'h310);
        send_byte(8'h01, 1'b0, 0, 12'h000);
        idle(2);
        send_byte(8'h00, 1'b0, KIND_WR, 12'h001);
`endif
        idle(5);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
